// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one external ALU between the EX stage (req 0)
// and the branch/address helper (req 1); IDLE -> EXEC -> RESP per operation.
module alu_arbiter #(
   parameter int NB_DATA      = 32,
   parameter int NB_OPERATION = 4
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic [1:0]              i_req_valid,
   output logic [1:0]              o_req_ready,
   input  logic [NB_OPERATION-1:0] i_req_op_0,
   input  logic [NB_OPERATION-1:0] i_req_op_1,
   input  logic [NB_DATA-1:0]      i_req_a_0,
   input  logic [NB_DATA-1:0]      i_req_a_1,
   input  logic [NB_DATA-1:0]      i_req_b_0,
   input  logic [NB_DATA-1:0]      i_req_b_1,
   output logic [1:0]              o_rsp_valid,
   input  logic [1:0]              i_rsp_ready,
   output logic [NB_DATA-1:0]      o_rsp_data,
   output logic [NB_OPERATION-1:0] o_alu_op,
   output logic [NB_DATA-1:0]      o_alu_data_a,
   output logic [NB_DATA-1:0]      o_alu_data_b,
   input  logic [NB_DATA-1:0]      i_alu_result,
   output logic                    o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                  r_state;
   logic                    r_ptr;
   logic                    r_id;
   logic [NB_OPERATION-1:0] r_op;
   logic [NB_DATA-1:0]      r_a;
   logic [NB_DATA-1:0]      r_b;
   logic [NB_DATA-1:0]      r_result;

   logic                    w_winner;
   logic                    w_handshake;
   logic                    w_accept;
   logic [NB_OPERATION-1:0] w_op;
   logic [NB_DATA-1:0]      w_a;
   logic [NB_DATA-1:0]      w_b;

   // A lone requester always wins; on contention the pointer breaks the tie.
   always_comb begin
      case (i_req_valid)
         2'b01:   w_winner = 1'b0;
         2'b10:   w_winner = 1'b1;
         default: w_winner = r_ptr;
      endcase
   end

   assign w_handshake = (r_state == ST_RESP) && i_rsp_ready[r_id];
   assign w_accept    = !i_reset && (|i_req_valid) &&
                        ((r_state == ST_IDLE) || w_handshake);

   assign w_op = w_winner ? i_req_op_1 : i_req_op_0;
   assign w_a  = w_winner ? i_req_a_1  : i_req_a_0;
   assign w_b  = w_winner ? i_req_b_1  : i_req_b_0;

   assign o_req_ready  = w_accept ? (w_winner ? 2'b10 : 2'b01) : 2'b00;
   assign o_rsp_valid  = (r_state == ST_RESP) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
   assign o_rsp_data   = r_result;
   assign o_alu_op     = r_op;
   assign o_alu_data_a = r_a;
   assign o_alu_data_b = r_b;
   assign o_busy       = (r_state != ST_IDLE);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_ptr    <= 1'b0;
         r_id     <= 1'b0;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
      end else begin
         if (w_accept) begin
            r_op  <= w_op;
            r_a   <= w_a;
            r_b   <= w_b;
            r_id  <= w_winner;
            r_ptr <= ~w_winner;
         end
         case (r_state)
            ST_IDLE: if (w_accept) r_state <= ST_EXEC;
            ST_EXEC: begin
               r_result <= i_alu_result;
               r_state  <= ST_RESP;
            end
            // A completing handshake can chain straight into the next operation.
            ST_RESP: if (w_handshake) r_state <= w_accept ? ST_EXEC : ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  op0, op1;
   logic [31:0] a0, a1, b0, b1;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_data;
   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_res;
   logic        busy;

   int total = 0;
   int bad   = 0;

   alu_arbiter #(.NB_DATA(32), .NB_OPERATION(4)) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_op_0   (op0),
      .i_req_op_1   (op1),
      .i_req_a_0    (a0),
      .i_req_a_1    (a1),
      .i_req_b_0    (b0),
      .i_req_b_1    (b1),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_data   (rsp_data),
      .o_alu_op     (alu_op),
      .o_alu_data_a (alu_a),
      .o_alu_data_b (alu_b),
      .i_alu_result (alu_res),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU model: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed), others all-ones
   always_comb begin
      case (alu_op)
         4'd0:    alu_res = alu_a + alu_b;
         4'd1:    alu_res = alu_a - alu_b;
         4'd2:    alu_res = alu_a & alu_b;
         4'd3:    alu_res = alu_a | alu_b;
         4'd4:    alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         default: alu_res = 32'hFFFF_FFFF;
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      op0 = 4'd0; op1 = 4'd0;
      a0 = 32'd0; a1 = 32'd0; b0 = 32'd0; b1 = 32'd0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      req_valid = 2'b01;
      step();
      step();
      @(negedge clk);
      if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
      total++;
      if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++;
      if (rsp_data !== 32'd0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
      total++;
      if ({alu_op, alu_a, alu_b} !== 68'd0) begin
         bad++; $display("FAIL reset_alu_out: got %h/%h/%h want 0/0/0", alu_op, alu_a, alu_b);
      end
      total++;
      step();
      rst = 1'b0;
      req_valid = 2'b00;
   endtask

   task automatic test_single_add();
      do_reset();
      req_valid = 2'b01; op0 = 4'd0; a0 = 32'd5; b0 = 32'd7;
      @(negedge clk);
      if (req_ready !== 2'b01) begin bad++; $display("FAIL add_ready: got %b want 01", req_ready); end
      total++;
      step();
      req_valid = 2'b00;
      @(negedge clk);
      if (alu_op !== 4'd0 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
         bad++; $display("FAIL add_alu_drive: got %h/%h/%h want 0/5/7", alu_op, alu_a, alu_b);
      end
      total++;
      if (busy !== 1'b1 || rsp_valid !== 2'b00) begin
         bad++; $display("FAIL add_exec: got busy=%b vld=%b want 1/00", busy, rsp_valid);
      end
      total++;
      step();
      @(negedge clk);
      if (rsp_valid !== 2'b01) begin bad++; $display("FAIL add_rsp_valid: got %b want 01", rsp_valid); end
      total++;
      if (rsp_data !== 32'd12) begin bad++; $display("FAIL add_rsp_data: got %h want c", rsp_data); end
      total++;
      rsp_ready = 2'b01;
      step();
      rsp_ready = 2'b00;
      @(negedge clk);
      if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_data !== 32'd12) begin
         bad++; $display("FAIL add_after: got busy=%b vld=%b data=%h want 0/00/c", busy, rsp_valid, rsp_data);
      end
      total++;
   endtask

   logic [1:0]  c_rdy  [0:8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
   logic [1:0]  c_vld  [0:8] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
   logic [31:0] c_data [0:8] = '{32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0, 32'h0000_00FF, 32'h0,
                                 32'hFFFF_FFFE, 32'h0, 32'h0000_00FF};

   task automatic test_contention();
      do_reset();
      req_valid = 2'b11; rsp_ready = 2'b11;
      op0 = 4'd1; a0 = 32'd3;    b0 = 32'd5;
      op1 = 4'd3; a1 = 32'hF0;   b1 = 32'h0F;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (req_ready !== c_rdy[c]) begin
            bad++; $display("FAIL fair_ready[%0d]: got %b want %b", c, req_ready, c_rdy[c]);
         end
         total++;
         if (rsp_valid !== c_vld[c]) begin
            bad++; $display("FAIL fair_rsp_valid[%0d]: got %b want %b", c, rsp_valid, c_vld[c]);
         end
         total++;
         if (c_vld[c] != 2'b00) begin
            if (rsp_data !== c_data[c]) begin
               bad++; $display("FAIL fair_rsp_data[%0d]: got %h want %h", c, rsp_data, c_data[c]);
            end
            total++;
         end
         step();
      end
      clear_inputs();
   endtask

   task automatic test_backpressure();
      do_reset();
      req_valid = 2'b10; op1 = 4'd4; a1 = 32'd2; b1 = 32'd9;
      @(negedge clk);
      if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_accept: got %b want 10", req_ready); end
      total++;
      step();
      req_valid = 2'b01; op0 = 4'd0; a0 = 32'd1; b0 = 32'd1;
      @(negedge clk);
      if (req_ready !== 2'b00) begin bad++; $display("FAIL bp_exec_ready: got %b want 00", req_ready); end
      total++;
      step();
      for (int c = 0; c < 3; c++) begin
         // the requester-0 ready bit must not complete requester 1's response
         rsp_ready = (c == 1) ? 2'b01 : 2'b00;
         @(negedge clk);
         if (rsp_valid !== 2'b10 || rsp_data !== 32'd1) begin
            bad++; $display("FAIL bp_hold[%0d]: got vld=%b data=%h want 10/1", c, rsp_valid, rsp_data);
         end
         total++;
         if (req_ready !== 2'b00) begin
            bad++; $display("FAIL bp_ready[%0d]: got %b want 00", c, req_ready);
         end
         total++;
         step();
      end
      rsp_ready = 2'b10;
      @(negedge clk);
      if (req_ready !== 2'b01 || rsp_valid !== 2'b10) begin
         bad++; $display("FAIL bp_release: got rdy=%b vld=%b want 01/10", req_ready, rsp_valid);
      end
      total++;
      step();
      req_valid = 2'b00; rsp_ready = 2'b00;
      @(negedge clk);
      if (busy !== 1'b1 || rsp_valid !== 2'b00 || alu_op !== 4'd0 || alu_a !== 32'd1) begin
         bad++; $display("FAIL bp_chain_exec: got busy=%b vld=%b op=%h a=%h want 1/00/0/1", busy, rsp_valid, alu_op, alu_a);
      end
      total++;
      step();
      @(negedge clk);
      if (rsp_valid !== 2'b01 || rsp_data !== 32'd2) begin
         bad++; $display("FAIL bp_chain_rsp: got vld=%b data=%h want 01/2", rsp_valid, rsp_data);
      end
      total++;
      rsp_ready = 2'b01;
      step();
      rsp_ready = 2'b00;
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      req_valid = 2'b01; op0 = 4'd0; a0 = 32'd5; b0 = 32'd7;
      @(negedge clk);
      if (req_ready !== 2'b01) begin bad++; $display("FAIL rmid_accept: got %b want 01", req_ready); end
      total++;
      step();
      req_valid = 2'b00; rst = 1'b1;
      step();
      rst = 1'b0; rsp_ready = 2'b11;
      @(negedge clk);
      if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
         bad++; $display("FAIL rmid_idle: got busy=%b vld=%b want 0/00", busy, rsp_valid);
      end
      total++;
      for (int c = 0; c < 4; c++) begin
         step();
         @(negedge clk);
         if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            bad++; $display("FAIL rmid_no_rsp[%0d]: got vld=%b busy=%b want 00/0", c, rsp_valid, busy);
         end
         total++;
      end
      step();
      req_valid = 2'b11;
      @(negedge clk);
      if (req_ready !== 2'b01) begin bad++; $display("FAIL rmid_ptr: got %b want 01", req_ready); end
      total++;
      step();
      clear_inputs();
      do_reset();
   endtask

   task automatic test_undefined_op();
      do_reset();
      req_valid = 2'b10; op1 = 4'hF; a1 = 32'd123; b1 = 32'd456;
      @(negedge clk);
      if (req_ready !== 2'b10) begin bad++; $display("FAIL undef_accept: got %b want 10", req_ready); end
      total++;
      step();
      req_valid = 2'b00;
      @(negedge clk);
      if (alu_op !== 4'hF) begin bad++; $display("FAIL undef_alu_op: got %h want f", alu_op); end
      total++;
      step();
      @(negedge clk);
      if (rsp_valid !== 2'b10 || rsp_data !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL undef_rsp: got vld=%b data=%h want 10/ffffffff", rsp_valid, rsp_data);
      end
      total++;
      rsp_ready = 2'b10;
      step();
      rsp_ready = 2'b00;
   endtask

   task automatic test_idle_stable();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (busy !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
            bad++; $display("FAIL idle_ctrl[%0d]: got busy=%b rdy=%b vld=%b want 0/00/00", c, busy, req_ready, rsp_valid);
         end
         total++;
         if (alu_op !== 4'hF || alu_a !== 32'd123 || alu_b !== 32'd456 || rsp_data !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL idle_hold[%0d]: got %h/%h/%h/%h want f/7b/1c8/ffffffff", c, alu_op, alu_a, alu_b, rsp_data);
         end
         total++;
         step();
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_single_add();
      test_contention();
      test_backpressure();
      test_reset_mid_op();
      test_undefined_op();
      test_idle_stable();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
